seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port ctrl  input  4  operation select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  result (low word for MUL).
REQ-012 SHALL have port result_hi  output  WIDTH  MUL high word; 0 for other ops.
REQ-013 SHALL have port zero  output  1  result == 0 (low word only).
REQ-014 SHALL have port overflow  output  1  signed overflow, ADD/SUB only.
REQ-015 SHALL have port cout  output  1  carry out of adder, ADD/SUB only.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, HOLD; in_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where in_valid && in_ready, capturing ctrl, a, b.
REQ-018 SHALL, for non-MUL ops, go IDLE -> HOLD on accept, outputs registered at that edge: out_valid high the cycle after accept (latency 1).
REQ-019 SHALL, for MUL, go IDLE -> BUSY, run unsigned shift-add one multiplier bit per cycle for exactly WIDTH cycles, then -> HOLD; out_valid high WIDTH+1 cycles after accept edge... precisely: asserted after the WIDTH-th BUSY edge.
REQ-020 SHALL compute MUL as full unsigned 2*WIDTH product {result_hi, result}.
REQ-021 SHALL compute SUB as a + ~b + 1; cout = carry out of MSB (1 = no borrow).
REQ-022 SHALL set overflow = carry into MSB XOR carry out of MSB for ADD/SUB; 0 otherwise.
REQ-023 SHALL compute SLT as signed a < b = (sub MSB XOR sub overflow), result = {0..0, slt}; correct at overflow boundaries.
REQ-024 SHALL compute NOR as ~(a | b); AND/OR bitwise.
REQ-025 SHALL, for undefined ctrl, complete in latency 1 with result = 0, result_hi = 0, zero = 1, overflow = 0, cout = 0.
REQ-026 SHALL hold out_valid and all result outputs stable in HOLD until out_ready sampled high; then -> IDLE, out_valid = 0.
REQ-027 SHALL NOT accept a request in the HOLD cycle where out_ready is high (one-cycle bubble); next request accepted earliest in the following IDLE cycle.
REQ-028 SHALL ignore in_valid and operand changes while in BUSY or HOLD.
REQ-029 SHALL keep outputs of the previous op stable in IDLE/BUSY, with out_valid = 0.

Reset
REQ-030 SHALL, on rising edge with rst = 1, enter IDLE: out_valid = 0, result = 0, result_hi = 0, zero = 1, overflow = 0, cout = 0, MUL counter/accumulator cleared.
REQ-031 SHALL give rst priority over in_valid and out_ready on the same edge; a request presented with rst high is not accepted.
REQ-032 SHALL abort an in-progress MUL or pending HOLD on reset; no out_valid for the aborted op.

Verification
REQ-033 SHALL verify WIDTH=32 ADD a=0x7FFFFFFF b=1 -> 1 cycle later result=0x80000000, overflow=1, cout=0, zero=0.
REQ-034 SHALL verify WIDTH=32 SLT a=0x80000000 b=0x00000001 -> result=1; SUB 5-5 -> result=0, zero=1, cout=1.
REQ-035 SHALL verify WIDTH=8 MUL a=0xFF b=0xFF -> out_valid exactly 8 BUSY edges after accept, result_hi=0xFE, result=0x01.
REQ-036 SHALL verify backpressure: out_ready held 0 for 5 cycles -> out_valid and result stable, in_ready=0; in_valid pulsed during HOLD not accepted.
REQ-037 SHALL verify rst asserted at MUL cycle 3 -> next cycle IDLE, in_ready=1, out_valid never asserted, result=0.
REQ-038 SHALL verify ctrl=1111 -> result=0, zero=1, latency 1; back-to-back ADDs with out_ready=1 accepted every 2 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus a WIDTH-cycle unsigned shift-add multiplier,
// with a valid/ready handshake on both sides and results held until the consumer takes them.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;

  logic               is_sub;
  logic [WIDTH-1:0]   b_x;
  logic [WIDTH:0]     sum_full;
  logic [WIDTH-1:0]   sum_low;
  logic               add_cout;
  logic               add_ovf;
  logic               slt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_cout;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;

  // Shared adder for ADD/SUB/SLT; the carry into the MSB comes from a separate low-bits sum.
  always_comb begin
    is_sub   = (ctrl == OP_SUB) || (ctrl == OP_SLT);
    b_x      = is_sub ? ~b : b;
    sum_full = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, is_sub};
    sum_low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, is_sub};
    add_cout = sum_full[WIDTH];
    add_ovf  = sum_low[WIDTH-1] ^ add_cout;
    slt      = sum_full[WIDTH-1] ^ add_ovf;
  end

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    case (ctrl)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res  = sum_full[WIDTH-1:0];
        alu_ovf  = add_ovf;
        alu_cout = add_cout;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per cycle: the low half of prod holds the remaining multiplier bits.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod_next = {mul_sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      prod      <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (ctrl == OP_MUL) begin
              state <= BUSY;
              count <= '0;
              mcand <= a;
              prod  <= {{WIDTH{1'b0}}, b};
            end else begin
              state     <= HOLD;
              result    <= alu_res;
              result_hi <= '0;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              cout      <= alu_cout;
            end
          end
        end
        BUSY: begin
          prod  <= prod_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state     <= HOLD;
            result    <= prod_next[WIDTH-1:0];
            result_hi <= prod_next[2*WIDTH-1:WIDTH];
            zero      <= (prod_next[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            cout      <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a transaction-level reference model checked every cycle against a 32-bit
// instance, directed corner cases with literal expectations, and an 8-bit multiply check.
module tb_seq_alu;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ovf;
    logic        co;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        cout;

  logic        rst8;
  logic        in_valid8;
  logic        in_ready8;
  logic [3:0]  ctrl8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic [7:0]  result_hi8;
  logic        zero8;
  logic        overflow8;
  logic        cout8;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  logic  m_pending = 0;
  logic  m_valid = 0;
  int    m_wait = 0;
  exp_t  m_exp = '{res: 32'h0, hi: 32'h0, z: 1'b1, ovf: 1'b0, co: 1'b0};
  exp_t  m_next = '0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .overflow(overflow), .cout(cout)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .ctrl(ctrl8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .result_hi(result_hi8), .zero(zero8), .overflow(overflow8), .cout(cout8)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic exp_t refOp(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    logic [32:0] s;
    logic [63:0] p;
    r = '0;
    s = '0;
    p = '0;
    case (c)
      4'b0000: r.res = x & y;
      4'b0001: r.res = x | y;
      4'b1100: r.res = ~(x | y);
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r.res = s[31:0];
        r.co  = s[32];
        r.ovf = (x[31] == y[31]) && (r.res[31] != x[31]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r.res = s[31:0];
        r.co  = s[32];
        r.ovf = (x[31] != y[31]) && (r.res[31] != x[31]);
      end
      4'b0111: r.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'h0, x} * {32'h0, y};
        r.res = p[31:0];
        r.hi  = p[63:32];
      end
      default: r.res = 32'h0;
    endcase
    r.z = (r.res == 32'h0);
    return r;
  endfunction

  // Transaction model: one op in flight at a time, visible after 0 (logic) or 32 (MUL) extra edges.
  always @(posedge clk) begin
    if (rst) begin
      m_pending <= 0;
      m_valid   <= 0;
      m_wait    <= 0;
      m_exp     <= '{res: 32'h0, hi: 32'h0, z: 1'b1, ovf: 1'b0, co: 1'b0};
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending <= 1;
        if (ctrl == 4'b1000) begin
          m_wait <= 32;
          m_next <= refOp(ctrl, a, b);
        end else begin
          m_valid <= 1;
          m_exp   <= refOp(ctrl, a, b);
        end
      end
    end else if (!m_valid) begin
      if (m_wait == 1) begin
        m_valid <= 1;
        m_exp   <= m_next;
      end
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      m_pending <= 0;
      m_valid   <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready", in_ready, !m_pending);
      checkOutput("out_valid", out_valid, m_valid);
      checkOutput("result", result, m_exp.res);
      checkOutput("result_hi", result_hi, m_exp.hi);
      checkOutput("zero", zero, m_exp.z);
      checkOutput("overflow", overflow, m_exp.ovf);
      checkOutput("cout", cout, m_exp.co);
    end
  end

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pickCtrl();
    case ($urandom_range(0, 7))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b1100;
      6: return 4'b1000;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic waitIdle();
    bit seen;
    seen = 0;
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1;
        break;
      end
    end
    checkOutput("idle_timeout", seen, 1'b1);
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid  = 1;
    ctrl      = c;
    a         = x;
    b         = y;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic releaseOut();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    int accepts;
    int n;
    bit saw_valid;
    logic [31:0] held;

    rst = 1; in_valid = 0; ctrl = 0; a = 0; b = 0; out_ready = 0;
    rst8 = 1; in_valid8 = 0; ctrl8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    check_en = 1;
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_zero", zero, 1'b1);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);

    waitIdle();
    applyStimulus(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    checkOutput("add_ovf_valid", out_valid, 1'b1);
    checkOutput("add_ovf_result", result, 32'h80000000);
    checkOutput("add_ovf_overflow", overflow, 1'b1);
    checkOutput("add_ovf_cout", cout, 1'b0);
    checkOutput("add_ovf_zero", zero, 1'b0);
    releaseOut();

    waitIdle();
    applyStimulus(4'b0111, 32'h80000000, 32'h00000001);
    checkOutput("slt_min_result", result, 32'h1);
    releaseOut();

    waitIdle();
    applyStimulus(4'b0110, 32'd5, 32'd5);
    checkOutput("sub_eq_result", result, 32'h0);
    checkOutput("sub_eq_zero", zero, 1'b1);
    checkOutput("sub_eq_cout", cout, 1'b1);
    releaseOut();

    waitIdle();
    applyStimulus(4'b1111, 32'hDEADBEEF, 32'h12345678);
    checkOutput("undef_valid", out_valid, 1'b1);
    checkOutput("undef_result", result, 32'h0);
    checkOutput("undef_zero", zero, 1'b1);
    releaseOut();

    // Backpressure: result must sit still while new requests are waved at the block.
    waitIdle();
    applyStimulus(4'b0010, 32'h12345678, 32'h11111111);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_result", result, 32'h23456789);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      in_valid = (i % 2 == 0);
      ctrl = 4'b0010;
      a = $urandom;
      b = $urandom;
      out_ready = 0;
      @(negedge clk);
    end
    in_valid = 0;
    releaseOut();
    checkOutput("bp_after_valid", out_valid, 1'b0);
    checkOutput("bp_after_in_ready", in_ready, 1'b1);
    checkOutput("bp_after_result", result, 32'h23456789);

    // Reset during the third multiply cycle, with a request presented alongside it.
    waitIdle();
    applyStimulus(4'b1000, 32'hFFFF1234, 32'h00ABCDEF);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    in_valid = 1;
    ctrl = 4'b0010;
    a = 32'h5;
    b = 32'h6;
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    checkOutput("mulrst_in_ready", in_ready, 1'b1);
    checkOutput("mulrst_out_valid", out_valid, 1'b0);
    checkOutput("mulrst_result", result, 32'h0);
    saw_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    checkOutput("mulrst_no_valid", saw_valid, 1'b0);

    // Back-to-back ADDs with the consumer always ready: one accept every second cycle.
    waitIdle();
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) accepts++;
      in_valid = 1;
      ctrl = 4'b0010;
      a = pickOperand();
      b = pickOperand();
      out_ready = 1;
      @(negedge clk);
    end
    in_valid = 0;
    checkOutput("b2b_accepts", accepts, 5);

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = $urandom_range(0, 1);
      ctrl = pickCtrl();
      a = pickOperand();
      b = pickOperand();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    waitIdle();

    // 8-bit multiply: result appears exactly 8 edges after the accepting edge.
    @(negedge clk);
    rst8 = 0;
    in_valid8 = 1;
    ctrl8 = 4'b1000;
    a8 = 8'hFF;
    b8 = 8'hFF;
    @(negedge clk);
    in_valid8 = 0;
    a8 = 8'h00;
    n = 0;
    while (!out_valid8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mul8_latency", n, 8);
    checkOutput("mul8_result", result8, 8'h01);
    checkOutput("mul8_result_hi", result_hi8, 8'hFE);
    checkOutput("mul8_zero", zero8, 1'b0);
    held = {24'h0, result8};
    out_ready8 = 1;
    @(negedge clk);
    checkOutput("mul8_release", out_valid8, 1'b0);
    checkOutput("mul8_hold_idle", {24'h0, result8}, held);

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
